// File: rtl/fetch_decode_sequencer_if.sv
// Fetch/decode sequencer bus: instruction-memory handshake plus decoded PC control lines.
// master = sequencer side, slave = PC/memory side.
interface fds_if #(
   parameter int IW = 8,
   parameter int AW = 4
);
   logic [AW-1:0] pc;
   logic          imem_req;
   logic [AW-1:0] imem_addr;
   logic          imem_ack;
   logic [IW-1:0] imem_data;
   logic          pc_ce;
   logic          pl;
   logic          jb;
   logic          bc;
   logic [AW-1:0] addr;
   logic [1:0]    laddr;
   logic [1:0]    raddr;
   logic          alu_go;
   logic          halted;
   logic          fault;
   logic [7:0]    retired;

   modport master (
      input  pc, imem_ack, imem_data,
      output imem_req, imem_addr, pc_ce, pl, jb, bc, addr, laddr, raddr,
             alu_go, halted, fault, retired
   );

   modport slave (
      output pc, imem_ack, imem_data,
      input  imem_req, imem_addr, pc_ce, pl, jb, bc, addr, laddr, raddr,
             alu_go, halted, fault, retired
   );
endinterface

// File: rtl/fetch_decode_sequencer.sv
// Fetches the word at PC, decodes it into PC control lines and strobes PC_CE once per retired instruction.
// 3 cycles per instruction with same-cycle ACK, +1 per WAIT cycle; a missing ACK faults after ACK_TIMEOUT WAIT cycles.
module fetch_decode_sequencer #(
   parameter int IW          = 8,
   parameter int AW          = 4,
   parameter int ACK_TIMEOUT = 15
) (
   input  logic   clk_i,
   input  logic   rst_n_i,
   fds_if.master  bus
);

   typedef enum logic [2:0] {
      S_FETCH,
      S_WAIT,
      S_DECODE,
      S_EXEC,
      S_HALT
   } state_e;

   state_e        state_q, state_d;
   logic [IW-1:0] ir_q, ir_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [7:0]    cnt_q, cnt_d;
   logic          halted_q, halted_d;
   logic          fault_q, fault_d;
   logic [7:0]    retired_q, retired_d;

   logic          req;
   logic          pc_ce;
   logic          alu_go;
   logic [AW-1:0] imem_addr;
   logic [3:0]    opc;

   assign opc = ir_q[7:4];

   always_comb begin
      state_d   = state_q;
      ir_d      = ir_q;
      addr_d    = addr_q;
      cnt_d     = cnt_q;
      halted_d  = halted_q;
      fault_d   = fault_q;
      retired_d = retired_q;
      req       = 1'b0;
      pc_ce     = 1'b0;
      alu_go    = 1'b0;
      imem_addr = addr_q;

      case (state_q)
         S_FETCH: begin
            req       = 1'b1;
            imem_addr = bus.pc;
            addr_d    = bus.pc;
            cnt_d     = '0;
            if (bus.imem_ack) begin
               ir_d    = bus.imem_data;
               state_d = S_DECODE;
            end else begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            req = 1'b1;
            if (bus.imem_ack) begin
               ir_d    = bus.imem_data;
               state_d = S_DECODE;
            end else begin
               cnt_d = cnt_q + 8'd1;
               // The ACK_TIMEOUT-th silent WAIT cycle is the last one.
               if (cnt_q == 8'(ACK_TIMEOUT - 1)) begin
                  fault_d  = 1'b1;
                  halted_d = 1'b1;
                  state_d  = S_HALT;
               end
            end
         end
         S_DECODE: begin
            if (opc == 4'hF) begin
               halted_d = 1'b1;
               state_d  = S_HALT;
            end else begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            pc_ce     = 1'b1;
            alu_go    = (opc >= 4'h1) && (opc <= 4'h7);
            retired_d = retired_q + 8'd1;
            state_d   = S_FETCH;
         end
         S_HALT: begin
            state_d = S_HALT;
         end
         default: begin
            state_d = S_FETCH;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q   <= S_FETCH;
         ir_q      <= '0;
         addr_q    <= '0;
         cnt_q     <= '0;
         halted_q  <= 1'b0;
         fault_q   <= 1'b0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         ir_q      <= ir_d;
         addr_q    <= addr_d;
         cnt_q     <= cnt_d;
         halted_q  <= halted_d;
         fault_q   <= fault_d;
         retired_q <= retired_d;
      end
   end

   // Strobes are masked while reset is held so a reset cycle never requests or retires.
   assign bus.imem_req  = req && rst_n_i;
   assign bus.pc_ce     = pc_ce && rst_n_i;
   assign bus.alu_go    = alu_go && rst_n_i;
   assign bus.imem_addr = imem_addr;

   // Decoded lines come straight from IR, so they hold from DECODE through EXEC.
   assign bus.pl      = (opc == 4'h8) || (opc == 4'h9) || (opc == 4'hA);
   assign bus.jb      = (opc == 4'h8);
   assign bus.bc      = (opc == 4'hA);
   assign bus.addr    = AW'(ir_q[3:0]);
   assign bus.laddr   = ir_q[3:2];
   assign bus.raddr   = ir_q[1:0];
   assign bus.halted  = halted_q;
   assign bus.fault   = fault_q;
   assign bus.retired = retired_q;

endmodule

// File: tb/tb_fetch_decode_sequencer.sv
// Randomized bench for fetch_decode_sequencer: drives memory and PC, checks every cycle
// against an instruction-level timing model.
module tb_fetch_decode_sequencer;
   localparam int IW = 8;
   localparam int AW = 4;
   localparam int TO = 15;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   fds_if #(.IW(IW), .AW(AW)) bus ();

   fetch_decode_sequencer #(.IW(IW), .AW(AW), .ACK_TIMEOUT(TO)) dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   int            checks = 0;
   int            errors = 0;
   logic [AW-1:0] pc_m   = '0;
   logic [7:0]    ret_m  = '0;

   assign bus.pc = pc_m;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected {PL,JB,BC,ADDR,LADDR,RADDR} for an instruction word, straight from the opcode table.
   function automatic logic [10:0] fields_of(input logic [7:0] w);
      int  op;
      logic pl, jb, bc;
      op = int'(w[7:4]);
      pl = (op == 8) || (op == 9) || (op == 10);
      jb = (op == 8);
      bc = (op == 10);
      return {pl, jb, bc, w[3:0], w[3:2], w[1:0]};
   endfunction

   function automatic logic [10:0] fields_obs();
      return {bus.pl, bus.jb, bus.bc, bus.addr, bus.laddr, bus.raddr};
   endfunction

   // Runs one instruction starting in a FETCH cycle; ACK comes on the (dly+1)-th request cycle.
   task automatic run_instr(input logic [7:0] w, input int dly);
      int op;
      op = int'(w[7:4]);
      for (int k = 0; k <= dly; k++) begin
         bus.imem_ack  = (k == dly);
         bus.imem_data = (k == dly) ? w : 8'($urandom);
         #1;
         chk("req_fetch", 32'(bus.imem_req), 1);
         chk("imem_addr", 32'(bus.imem_addr), 32'(pc_m));
         chk("pc_ce_fetch", 32'(bus.pc_ce), 0);
         tick();
      end
      // ACK while REQ is low must be ignored.
      bus.imem_ack  = 1'($urandom_range(0, 1));
      bus.imem_data = 8'($urandom);
      #1;
      chk("req_decode", 32'(bus.imem_req), 0);
      chk("pc_ce_decode", 32'(bus.pc_ce), 0);
      chk("fields_decode", 32'(fields_obs()), 32'(fields_of(w)));
      tick();
      if (op == 15) begin
         bus.imem_ack = 1'b0;
         #1;
         chk("halted_op", 32'(bus.halted), 1);
         chk("pc_ce_halt", 32'(bus.pc_ce), 0);
         chk("req_halt", 32'(bus.imem_req), 0);
      end else begin
         bus.imem_ack  = 1'($urandom_range(0, 1));
         bus.imem_data = 8'($urandom);
         #1;
         chk("pc_ce_exec", 32'(bus.pc_ce), 1);
         chk("alu_go", 32'(bus.alu_go), 32'((op >= 1) && (op <= 7)));
         chk("fields_exec", 32'(fields_obs()), 32'(fields_of(w)));
         chk("req_exec", 32'(bus.imem_req), 0);
         tick();
         ret_m = ret_m + 8'd1;
         if (op == 8) pc_m = w[3:0];
         else         pc_m = pc_m + 4'd1;
         bus.imem_ack = 1'b0;
         chk("retired", 32'(bus.retired), 32'(ret_m));
      end
   endtask

   task automatic reset_check(input string tag);
      bus.imem_ack  = 1'b1;
      bus.imem_data = 8'h83;
      rst_n = 1'b0;
      #1;
      chk({tag, "_req"}, 32'(bus.imem_req), 0);
      tick();
      chk({tag, "_req_held"}, 32'(bus.imem_req), 0);
      chk({tag, "_pc_ce"}, 32'(bus.pc_ce), 0);
      chk({tag, "_halted"}, 32'(bus.halted), 0);
      chk({tag, "_fault"}, 32'(bus.fault), 0);
      chk({tag, "_retired"}, 32'(bus.retired), 0);
      chk({tag, "_fields"}, 32'(fields_obs()), 0);
      bus.imem_ack = 1'b0;
      rst_n = 1'b1;
      ret_m = '0;
   endtask

   initial begin
      logic [7:0] w;
      int         d;
      bus.imem_ack  = 1'b1;
      bus.imem_data = 8'h83;
      tick();
      reset_check("rst0");

      for (int i = 0; i < 3; i++) run_instr(8'h00, 0);
      run_instr(8'h83, 0);
      run_instr(8'h96, 0);
      run_instr(8'hA6, 0);
      run_instr(8'h12, 4);

      // Reset in the middle of a WAIT.
      bus.imem_ack = 1'b0;
      #1;
      chk("mid_req0", 32'(bus.imem_req), 1);
      tick();
      chk("mid_req1", 32'(bus.imem_req), 1);
      tick();
      reset_check("rst_wait");
      #1;
      chk("mid_fetch_req", 32'(bus.imem_req), 1);
      chk("mid_fetch_addr", 32'(bus.imem_addr), 32'(pc_m));
      run_instr(8'h05, 0);

      // Enough instructions to wrap RETIRED.
      for (int i = 0; i < 270; i++) begin
         w = {4'($urandom_range(0, 14)), 4'($urandom)};
         d = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0;
         run_instr(w, d);
      end

      run_instr(8'hF0, 0);
      for (int i = 0; i < 3; i++) begin
         bus.imem_ack = 1'b1;
         tick();
         chk("halt_sticky", 32'({bus.halted, bus.fault, bus.imem_req, bus.pc_ce}), 32'h8);
      end
      reset_check("rst_halt");

      // Memory never answers: TO silent WAIT cycles after FETCH, then fault.
      bus.imem_ack = 1'b0;
      for (int k = 0; k <= TO; k++) begin
         #1;
         chk("to_req", 32'(bus.imem_req), 1);
         chk("to_fault_early", 32'(bus.fault), 0);
         tick();
      end
      chk("to_fault", 32'(bus.fault), 1);
      chk("to_halted", 32'(bus.halted), 1);
      chk("to_req_drop", 32'(bus.imem_req), 0);
      for (int i = 0; i < 3; i++) begin
         bus.imem_ack = 1'b1;
         tick();
         chk("to_late_ack", 32'({bus.halted, bus.fault, bus.imem_req, bus.pc_ce}), 32'hC);
      end
      reset_check("rst_fault");
      run_instr(8'h21, 2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/fetch_decode_sequencer.md
Name: fetch_decode_sequencer

Overview:
Control stage that sits directly upstream of the program counter. It fetches the instruction at the current PC from instruction memory over a req/ack handshake and latches it into an instruction register. It decodes the instruction into the PC control lines (PL, JB, BC, ADDR, LADDR, RADDR) and issues a one-cycle PC update strobe, so the PC advances exactly once per retired instruction.

Parameters:
IW, 8, instruction width; OPC = IR[7:4], LADDR = IR[3:2], RADDR = IR[1:0], ADDR = IR[3:0]
AW, 4, PC / instruction-memory address width
ACK_TIMEOUT, 15, maximum cycles to wait for IMEM_ACK before faulting (1..255)

Ports:
CLK  in  1  system clock, all state updates on posedge
RST_N  in  1  synchronous active-low reset, sampled on posedge CLK
PC  in  AW  current program counter value
IMEM_REQ  out  1  fetch request
IMEM_ADDR  out  AW  fetch address
IMEM_ACK  in  1  memory has valid IMEM_DATA this cycle
IMEM_DATA  in  IW  instruction word
PC_CE  out  1  one-cycle strobe; the PC updates only when PC_CE=1
PL  out  1  0 = increment, 1 = load/branch
JB  out  1  1 = unconditional jump to ADDR
BC  out  1  branch-condition select (1 = negative, 0 = zero)
ADDR  out  AW  jump target / branch test value
LADDR  out  2  register-field / branch-offset high
RADDR  out  2  register-field / branch-offset low
ALU_GO  out  1  one-cycle strobe for ALU opcodes
HALTED  out  1  sticky; set in HALT or FAULT
FAULT  out  1  sticky; memory timeout
RETIRED  out  8  retired-instruction count, wraps at 255 -> 0

Behaviour:
- Reset: when RST_N=0 at a posedge, state is FETCH and IR=8'h00. All outputs are 0 except IMEM_ADDR. Timeout counter and RETIRED are cleared. Reset overrides any state, including an in-flight fetch; an ACK arriving in the reset cycle is discarded.
- States: FETCH, WAIT, DECODE, EXEC, HALT.
- FETCH: assert IMEM_REQ=1 and IMEM_ADDR=PC; capture PC into the address register; clear the timeout counter. If IMEM_ACK=1 in this cycle, latch IR and go to DECODE. Otherwise go to WAIT.
- WAIT: hold IMEM_REQ=1 and IMEM_ADDR stable at the captured address.
  - On IMEM_ACK=1: latch IMEM_DATA into IR, drop REQ next cycle, go to DECODE.
  - Timeout counter increments each WAIT cycle. When it reaches ACK_TIMEOUT without an ACK, set FAULT=1 and HALTED=1 and go to HALT.
- An ACK while REQ=0 is ignored.
- DECODE: drive PL/JB/BC/ADDR/LADDR/RADDR from IR. These stay registered and stable through EXEC.
- Opcode map:
  - 0000 NOP: PL=0
  - 0001..0111 ALU op: PL=0, ALU_GO pulses in EXEC
  - 1000 JMP: PL=1, JB=1
  - 1001 BRZ: PL=1, JB=0, BC=0
  - 1010 BRN: PL=1, JB=0, BC=1
  - 1111 HALT: no PC_CE; go to HALT from DECODE; HALTED=1
  - any other opcode: treated as NOP
- EXEC: PC_CE=1 for exactly one cycle; RETIRED increments; next state is FETCH. The PC value is sampled in FETCH one cycle later and is therefore already updated.
- Latency: with ACK in the same cycle as REQ, 3 cycles per instruction (FETCH, DECODE, EXEC). Each extra WAIT cycle adds one.
- PC_CE and ALU_GO are never asserted outside EXEC, and never in two consecutive cycles.
- HALT: all strobes are 0 and IMEM_REQ=0. Only RST_N exits this state.

Test Plan:
- Reset then memory returning 8'h00 with ACK the same cycle as REQ -> PC_CE pulses every 3rd cycle; PL=0; RETIRED=1,2,3...
- IMEM_DATA=8'h83 (JMP 3) -> PL=1, JB=1, ADDR=4'h3 during EXEC; exactly one PC_CE; next IMEM_ADDR=3.
- IMEM_DATA=8'h96 (BRZ) -> PL=1, JB=0, BC=0, LADDR=2'b01, RADDR=2'b10. With 8'hA6 (BRN): BC=1.
- ACK delayed 4 cycles -> IMEM_REQ is held 5 cycles with IMEM_ADDR constant; no PC_CE until after DECODE.
- No ACK for ACK_TIMEOUT cycles -> FAULT=1, HALTED=1, REQ drops; ACK arriving afterwards is ignored; RST_N=0 clears both flags.
- 8'hF0 (HALT) -> no PC_CE and HALTED=1. RST_N asserted mid-WAIT -> next cycle is FETCH with RETIRED=0.
